// File: rtl/ysyx_22040175_pipe_chain_pkg.sv
// Shared constants for the CPU pipeline register chain: default depth, payload field
// offsets of the CPU stage bundles, and the per-slice update decision.
package ysyx_22040175_pipe_chain_pkg;

   localparam int PIPE_STAGES_DEF = 4;

   // Bit offsets of fields inside each slice payload, one group per CPU bundle.
   localparam int IF_ID_PC_OFF    = 0;
   localparam int IF_ID_INST_OFF  = 64;
   localparam int ID_EX_PC_OFF    = 0;
   localparam int ID_EX_IMM_OFF   = 64;
   localparam int EX_MEM_ALU_OFF  = 0;
   localparam int EX_MEM_WDAT_OFF = 64;
   localparam int MEM_WB_RES_OFF  = 0;
   localparam int MEM_WB_RD_OFF   = 64;

   typedef enum logic [1:0] {
      SLICE_HOLD,
      SLICE_DRAIN,
      SLICE_LOAD,
      SLICE_FLUSH
   } slice_op_e;

   // Flush beats load, load beats a plain handoff.
   function automatic slice_op_e slice_op(input logic flush, input logic load, input logic adv);
      slice_op_e op;
      op = SLICE_HOLD;
      if (flush)     op = SLICE_FLUSH;
      else if (load) op = SLICE_LOAD;
      else if (adv)  op = SLICE_DRAIN;
      return op;
   endfunction

endpackage

// File: rtl/ysyx_22040175_pipe_slice.sv
// One valid+payload register of the chain; applies flush > load > drain > hold.
// Single-cycle update; handshake decisions (load/adv) are made by the parent.
module ysyx_22040175_pipe_slice
   import ysyx_22040175_pipe_chain_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              load,
   input  logic              adv,
   input  logic [DATA_W-1:0] din,
   output logic              valid,
   output logic [DATA_W-1:0] data
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      unique case (slice_op(flush, load, adv))
         SLICE_FLUSH: valid_d = 1'b0;
         SLICE_LOAD: begin
            valid_d = 1'b1;
            data_d  = din;
         end
         SLICE_DRAIN: valid_d = 1'b0;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;

endmodule

// File: rtl/ysyx_22040175_pipe_chain.sv
// N-slice valid/ready register chain with per-slice stall, selective flush and perf counters.
// STAGES cycles accept-to-output; rdy ripples combinationally from out_ready to in_ready.
module ysyx_22040175_pipe_chain
   import ysyx_22040175_pipe_chain_pkg::*;
#(
   parameter int STAGES = PIPE_STAGES_DEF,
   parameter int DATA_W = 64,
   parameter int CNT_W  = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic [DATA_W-1:0]        in_data,
   output logic                     in_ready,
   input  logic [STAGES-1:0]        stall_req,
   input  logic [STAGES-1:0]        flush_mask,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   input  logic                     out_ready,
   output logic [STAGES-1:0]        stage_valid,
   output logic [STAGES*DATA_W-1:0] stage_data,
   input  logic                     cnt_clr,
   output logic [CNT_W-1:0]         stall_cnt,
   output logic [CNT_W-1:0]         flush_cnt
);

   logic [STAGES:0]   rdy;
   logic [STAGES-1:0] adv;
   logic [STAGES-1:0] load;
   logic [STAGES-1:0] valid;
   logic [DATA_W-1:0] data_arr [STAGES];

   always_comb begin
      rdy         = '0;
      adv         = '0;
      rdy[STAGES] = out_ready;
      for (int i = STAGES - 1; i >= 0; i--) begin
         adv[i] = valid[i] & ~stall_req[i] & rdy[i+1];
         rdy[i] = ~valid[i] | adv[i];
      end
   end

   // Handshakes are masked while reset is asserted so nothing is exchanged in that cycle.
   assign in_ready  = rdy[0] & rst_n;
   assign out_valid = valid[STAGES-1] & ~stall_req[STAGES-1] & rst_n;
   assign out_data  = data_arr[STAGES-1];

   for (genvar g = 0; g < STAGES; g++) begin : g_slice
      logic [DATA_W-1:0] din_w;
      if (g == 0) begin : g_head
         assign load[g] = in_valid & in_ready;
         assign din_w   = in_data;
      end else begin : g_body
         assign load[g] = adv[g-1];
         assign din_w   = data_arr[g-1];
      end

      ysyx_22040175_pipe_slice #(
         .DATA_W(DATA_W)
      ) u_slice (
         .clk   (clk),
         .rst_n (rst_n),
         .flush (flush_mask[g]),
         .load  (load[g]),
         .adv   (adv[g]),
         .din   (din_w),
         .valid (valid[g]),
         .data  (data_arr[g])
      );

      assign stage_data[g*DATA_W +: DATA_W] = data_arr[g];
   end

   assign stage_valid = valid;

   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [CNT_W:0]   flush_pop;
   logic [CNT_W:0]   flush_sum;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      flush_pop   = '0;
      for (int i = 0; i < STAGES; i++) begin
         flush_pop = flush_pop + (CNT_W+1)'(flush_mask[i] & valid[i]);
      end
      flush_sum = {1'b0, flush_cnt_q} + flush_pop;
      if (cnt_clr) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (in_valid && !in_ready && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
         // The carry bit catches wrap-around so the counter pins at all-ones.
         if (flush_sum[CNT_W]) flush_cnt_d = '1;
         else                  flush_cnt_d = flush_sum[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule
